sa_read_channel: RTL and testbench
==================================

// Module: sa_read_channel
// PURPOSE
//  Slave-side read arbiter; sits downstream of the per-master read dispatchers, one instance per slave.
//  Round-robin arbitrates the AR requests of MST_AMT dispatchers onto one registered slave AR port.
//  Records each granted master index in an in-order grant FIFO.
//  Routes the slave's R beats back to the master at the FIFO head, and retires an entry on RLAST.
// PARAMETERS
//  MST_AMT           2   number of dispatchers (masters) feeding this slave
//  OUTSTANDING_AMT   8   max AR accepted but not yet completed by RLAST (grant FIFO depth, power of 2)
//  DATA_WIDTH        32  RDATA width
//  ADDR_WIDTH        32  ARADDR width
//  TRANS_MST_ID_W    5   ARID/RID width
//  TRANS_BURST_W     2   ARBURST width
//  TRANS_DATA_LEN_W  3   ARLEN width
//  TRANS_DATA_SIZE_W 3   ARSIZE width
//  TRANS_WR_RESP_W   2   RRESP width
//  MST_IDX_W         max(1,$clog2(MST_AMT))  grant index width
// PORTS
//  ACLK_i       in   1                      clock; single clock domain
//  ARESET_i     in   1                      reset: synchronous, active-high
//  m_ARID_i     in   TRANS_MST_ID_W*MST_AMT packed per-master AR fields; slot k = master k
//  m_ARADDR_i   in   ADDR_WIDTH*MST_AMT
//  m_ARBURST_i  in   TRANS_BURST_W*MST_AMT
//  m_ARLEN_i    in   TRANS_DATA_LEN_W*MST_AMT
//  m_ARSIZE_i   in   TRANS_DATA_SIZE_W*MST_AMT
//  m_ARVALID_i  in   MST_AMT                AR request per master
//  m_ARREADY_o  out  MST_AMT                one-hot grant/accept
//  m_RID_o      out  TRANS_MST_ID_W         R fields broadcast to all masters
//  m_RDATA_o    out  DATA_WIDTH
//  m_RRESP_o    out  TRANS_WR_RESP_W
//  m_RLAST_o    out  1
//  m_RVALID_o   out  MST_AMT                R valid, one-hot to owning master
//  m_RREADY_i   in   MST_AMT
//  s_ARID_o, s_ARADDR_o, s_ARBURST_o, s_ARLEN_o, s_ARSIZE_o  out  field widths  registered AR to slave
//  s_ARVALID_o  out  1
//  s_ARREADY_i  in   1
//  s_RID_i, s_RDATA_i, s_RRESP_i, s_RLAST_i  in  field widths  R from slave
//  s_RVALID_i   in   1
//  s_RREADY_o   out  1
// BEHAVIOUR
//  Reset: all outputs are 0; rr_ptr=0; grant FIFO is empty (count=0); the AR output register is invalid.
//   In-flight AR and R state is discarded when reset is asserted mid-operation.
//  Slot free: slot_free = !s_ARVALID_o | s_ARREADY_i.
//  Can accept: can_acc = slot_free & (count < OUTSTANDING_AMT).
//   Count is the current value; a same-cycle pop does not free space for a push.
//  Grant: the first k with m_ARVALID_i[k], searching from rr_ptr upward with wrap.
//   m_ARREADY_o[k] = can_acc, combinational in the same cycle. At most one bit is set.
//  On accept: the AR register loads master k's fields and sets s_ARVALID_o=1 next cycle (latency 1).
//   Index k is pushed to the FIFO. rr_ptr <= (k+1) mod MST_AMT.
//   When there is no accept, rr_ptr holds.
//  s_ARVALID_o stays high with stable fields until s_ARREADY_i.
//   A drain and a new load in the same cycle give back-to-back issue with no bubble.
//  R path (combinational): head = FIFO front; active = count != 0.
//   m_RVALID_o = active ? (s_RVALID_i << head) : 0.
//   s_RREADY_o = active & m_RREADY_i[head].
//   R data fields pass straight through.
//  Pop: on s_RVALID_i & s_RREADY_o & s_RLAST_i. Non-last beats do not pop.
//  R beats arriving while the FIFO is empty (protocol error) are stalled (s_RREADY_o=0), never dropped.
//  Simultaneous push and pop: count is unchanged and both pointers advance.
//   Pointers wrap modulo OUTSTANDING_AMT.
//  Full (count == OUTSTANDING_AMT): every m_ARREADY_o is 0; R draining continues.
// STRUCTURE
//  Shared package axi_icn_pkg: AXI field-width constants and the MST_IDX_W derivation.
//  Sub-module sa_grant_fifo: sync FIFO of MST_IDX_W-bit entries with push, pop, front, count.
//  The arbiter, AR register and R mux stay in this module.
// TESTING
//  1. Reset, then idle: all outputs 0; assert ARESET_i mid-burst -> next cycle s_ARVALID_o=0, s_RREADY_o=0, count=0.
//  2. m_ARVALID_i=2'b11, s_ARREADY_i=1 -> grants in order 0,1,0,1; s_ARVALID_o is high every cycle from cycle 1.
//  3. Only master 1 requests with ARADDR=0x4000_0010 -> m_ARREADY_o=2'b10; s_ARADDR_o=0x4000_0010 one cycle later.
//  4. With OUTSTANDING_AMT=8, 8 ARs accepted and no R -> 9th request sees m_ARREADY_o=0.
//   One RLAST beat then frees the slot, and the grant follows on the next cycle.
//  5. ARs from masters 0,1,0 with ARLEN=3 and R of 4 beats each -> m_RVALID_o goes 01,10,01 per burst.
//   m_RREADY_i[0]=0 stalls s_RREADY_o.
//  6. s_ARREADY_i held 0 for 5 cycles -> s_AR fields stable, no further m_ARREADY_o, rr_ptr unchanged.

Source files
------------

// File: rtl/axi_icn_pkg.sv
// Shared AXI interconnect constants: default field widths and the grant-index width rule.
package axi_icn_pkg;

  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_ID_W    = 5;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_LEN_W   = 3;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_RESP_W  = 2;

  // A single master still needs a 1-bit index so vectors never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sa_grant_fifo.sv
// In-order FIFO of granted master indices; DEPTH must be a power of 2 (>= 2) so pointers wrap naturally.
module sa_grant_fifo
  import axi_icn_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] front,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: storage has no reset; count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign front = mem[rd_ptr];

endmodule

// File: rtl/sa_read_channel.sv
// Slave-side read arbiter: round-robin AR merge into a registered slave AR port, R routed back in grant order.
module sa_read_channel
  import axi_icn_pkg::*;
#(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int DATA_WIDTH        = AXI_DATA_W,
  parameter int ADDR_WIDTH        = AXI_ADDR_W,
  parameter int TRANS_MST_ID_W    = AXI_ID_W,
  parameter int TRANS_BURST_W     = AXI_BURST_W,
  parameter int TRANS_DATA_LEN_W  = AXI_LEN_W,
  parameter int TRANS_DATA_SIZE_W = AXI_SIZE_W,
  parameter int TRANS_WR_RESP_W   = AXI_RESP_W
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESET_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     m_ARID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]         m_ARADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]      m_ARBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   m_ARLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  m_ARSIZE_i,
  input  logic [MST_AMT-1:0]                    m_ARVALID_i,
  output logic [MST_AMT-1:0]                    m_ARREADY_o,
  output logic [TRANS_MST_ID_W-1:0]             m_RID_o,
  output logic [DATA_WIDTH-1:0]                 m_RDATA_o,
  output logic [TRANS_WR_RESP_W-1:0]            m_RRESP_o,
  output logic                                  m_RLAST_o,
  output logic [MST_AMT-1:0]                    m_RVALID_o,
  input  logic [MST_AMT-1:0]                    m_RREADY_i,
  output logic [TRANS_MST_ID_W-1:0]             s_ARID_o,
  output logic [ADDR_WIDTH-1:0]                 s_ARADDR_o,
  output logic [TRANS_BURST_W-1:0]              s_ARBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_ARLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]          s_ARSIZE_o,
  output logic                                  s_ARVALID_o,
  input  logic                                  s_ARREADY_i,
  input  logic [TRANS_MST_ID_W-1:0]             s_RID_i,
  input  logic [DATA_WIDTH-1:0]                 s_RDATA_i,
  input  logic [TRANS_WR_RESP_W-1:0]            s_RRESP_i,
  input  logic                                  s_RLAST_i,
  input  logic                                  s_RVALID_i,
  output logic                                  s_RREADY_o
);

  localparam int MST_IDX_W = idx_width(MST_AMT);
  localparam int CNT_W     = $clog2(OUTSTANDING_AMT) + 1;
  localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(OUTSTANDING_AMT);
  localparam logic [MST_IDX_W-1:0] LAST_MST = MST_IDX_W'(MST_AMT - 1);
  localparam logic [MST_AMT-1:0]   ONE_HOT0 = MST_AMT'(1);

  logic [MST_IDX_W-1:0] rr_ptr;
  logic [MST_IDX_W-1:0] grant_idx;
  logic [MST_IDX_W-1:0] head;
  logic [CNT_W-1:0]     count;
  logic                 req_found;
  logic                 slot_free;
  logic                 can_acc;
  logic                 accept;
  logic                 active;
  logic                 pop;

  logic [TRANS_MST_ID_W-1:0]    sel_id;
  logic [ADDR_WIDTH-1:0]        sel_addr;
  logic [TRANS_BURST_W-1:0]     sel_burst;
  logic [TRANS_DATA_LEN_W-1:0]  sel_len;
  logic [TRANS_DATA_SIZE_W-1:0] sel_size;

  // Round-robin: first pass covers indices at or above rr_ptr, second pass picks up the wrap.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    req_found = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < MST_AMT; k++) begin
      if (!req_found && m_ARVALID_i[k] && (MST_IDX_W'(k) >= rr_ptr)) begin
        req_found = 1'b1;
        grant_idx = MST_IDX_W'(k);
      end
    end
    for (int k = 0; k < MST_AMT; k++) begin
      if (!req_found && m_ARVALID_i[k]) begin
        req_found = 1'b1;
        grant_idx = MST_IDX_W'(k);
      end
    end
  end

  always_comb begin
    sel_id    = '0;
    sel_addr  = '0;
    sel_burst = '0;
    sel_len   = '0;
    sel_size  = '0;
    for (int k = 0; k < MST_AMT; k++) begin
      if (grant_idx == MST_IDX_W'(k)) begin
        sel_id    = m_ARID_i[k*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        sel_addr  = m_ARADDR_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_burst = m_ARBURST_i[k*TRANS_BURST_W +: TRANS_BURST_W];
        sel_len   = m_ARLEN_i[k*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
        sel_size  = m_ARSIZE_i[k*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
      end
    end
  end

  // A pop in the same cycle does not open space for a push; only the current count matters.
  assign slot_free   = !s_ARVALID_o || s_ARREADY_i;
  assign can_acc     = slot_free && (count < FULL_CNT);
  assign accept      = req_found && can_acc && !ARESET_i;
  assign m_ARREADY_o = accept ? (ONE_HOT0 << grant_idx) : '0;

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      rr_ptr      <= '0;
      s_ARVALID_o <= 1'b0;
      s_ARID_o    <= '0;
      s_ARADDR_o  <= '0;
      s_ARBURST_o <= '0;
      s_ARLEN_o   <= '0;
      s_ARSIZE_o  <= '0;
    end else if (accept) begin
      rr_ptr      <= (grant_idx == LAST_MST) ? '0 : grant_idx + 1'b1;
      s_ARVALID_o <= 1'b1;
      s_ARID_o    <= sel_id;
      s_ARADDR_o  <= sel_addr;
      s_ARBURST_o <= sel_burst;
      s_ARLEN_o   <= sel_len;
      s_ARSIZE_o  <= sel_size;
    end else if (s_ARREADY_i) begin
      s_ARVALID_o <= 1'b0;
    end
  end

  sa_grant_fifo #(
    .WIDTH (MST_IDX_W),
    .DEPTH (OUTSTANDING_AMT)
  ) u_grant_fifo (
    .clk       (ACLK_i),
    .rst       (ARESET_i),
    .push      (accept),
    .push_data (grant_idx),
    .pop       (pop),
    .front     (head),
    .count     (count)
  );

  // R beats with no recorded owner are held off rather than dropped.
  assign active     = (count != '0) && !ARESET_i;
  assign m_RVALID_o = (active && s_RVALID_i) ? (ONE_HOT0 << head) : '0;
  assign s_RREADY_o = active && m_RREADY_i[head];
  assign pop        = s_RVALID_i && s_RREADY_o && s_RLAST_i;

  assign m_RID_o   = s_RID_i;
  assign m_RDATA_o = s_RDATA_i;
  assign m_RRESP_o = s_RRESP_i;
  assign m_RLAST_o = s_RLAST_i;

endmodule

// File: tb/tb_sa_read_channel.sv
// Directed bench for sa_read_channel with two masters and eight outstanding reads.
module tb_sa_read_channel;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int BW = 2;
  localparam int LW = 3;
  localparam int SW = 3;
  localparam int RW = 2;

  logic              ACLK_i = 1'b0;
  logic              ARESET_i;
  logic [IW*NM-1:0]  m_ARID_i;
  logic [AW*NM-1:0]  m_ARADDR_i;
  logic [BW*NM-1:0]  m_ARBURST_i;
  logic [LW*NM-1:0]  m_ARLEN_i;
  logic [SW*NM-1:0]  m_ARSIZE_i;
  logic [NM-1:0]     m_ARVALID_i;
  logic [NM-1:0]     m_ARREADY_o;
  logic [IW-1:0]     m_RID_o;
  logic [DW-1:0]     m_RDATA_o;
  logic [RW-1:0]     m_RRESP_o;
  logic              m_RLAST_o;
  logic [NM-1:0]     m_RVALID_o;
  logic [NM-1:0]     m_RREADY_i;
  logic [IW-1:0]     s_ARID_o;
  logic [AW-1:0]     s_ARADDR_o;
  logic [BW-1:0]     s_ARBURST_o;
  logic [LW-1:0]     s_ARLEN_o;
  logic [SW-1:0]     s_ARSIZE_o;
  logic              s_ARVALID_o;
  logic              s_ARREADY_i;
  logic [IW-1:0]     s_RID_i;
  logic [DW-1:0]     s_RDATA_i;
  logic [RW-1:0]     s_RRESP_i;
  logic              s_RLAST_i;
  logic              s_RVALID_i;
  logic              s_RREADY_o;

  int n_cmp = 0;
  int n_err = 0;

  sa_read_channel dut (
    .ACLK_i      (ACLK_i),
    .ARESET_i    (ARESET_i),
    .m_ARID_i    (m_ARID_i),
    .m_ARADDR_i  (m_ARADDR_i),
    .m_ARBURST_i (m_ARBURST_i),
    .m_ARLEN_i   (m_ARLEN_i),
    .m_ARSIZE_i  (m_ARSIZE_i),
    .m_ARVALID_i (m_ARVALID_i),
    .m_ARREADY_o (m_ARREADY_o),
    .m_RID_o     (m_RID_o),
    .m_RDATA_o   (m_RDATA_o),
    .m_RRESP_o   (m_RRESP_o),
    .m_RLAST_o   (m_RLAST_o),
    .m_RVALID_o  (m_RVALID_o),
    .m_RREADY_i  (m_RREADY_i),
    .s_ARID_o    (s_ARID_o),
    .s_ARADDR_o  (s_ARADDR_o),
    .s_ARBURST_o (s_ARBURST_o),
    .s_ARLEN_o   (s_ARLEN_o),
    .s_ARSIZE_o  (s_ARSIZE_o),
    .s_ARVALID_o (s_ARVALID_o),
    .s_ARREADY_i (s_ARREADY_i),
    .s_RID_i     (s_RID_i),
    .s_RDATA_i   (s_RDATA_i),
    .s_RRESP_i   (s_RRESP_i),
    .s_RLAST_i   (s_RLAST_i),
    .s_RVALID_i  (s_RVALID_i),
    .s_RREADY_o  (s_RREADY_o)
  );

  always #5 ACLK_i = ~ACLK_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ar(input int k, input logic [AW-1:0] addr, input logic [IW-1:0] id,
                        input logic [LW-1:0] len);
    m_ARADDR_i[k*AW +: AW]  = addr;
    m_ARID_i[k*IW +: IW]    = id;
    m_ARLEN_i[k*LW +: LW]   = len;
    m_ARBURST_i[k*BW +: BW] = 2'b01;
    m_ARSIZE_i[k*SW +: SW]  = 3'd2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] owner [4];
    owner = '{2'b01, 2'b10, 2'b01, 2'b10};

    ARESET_i    = 1'b1;
    m_ARID_i    = '0;
    m_ARADDR_i  = '0;
    m_ARBURST_i = '0;
    m_ARLEN_i   = '0;
    m_ARSIZE_i  = '0;
    m_ARVALID_i = '0;
    m_RREADY_i  = '0;
    s_ARREADY_i = 1'b0;
    s_RID_i     = '0;
    s_RDATA_i   = '0;
    s_RRESP_i   = '0;
    s_RLAST_i   = 1'b0;
    s_RVALID_i  = 1'b0;
    repeat (3) @(negedge ACLK_i);
    ARESET_i = 1'b0;
    #1;

    // Idle after reset: everything low.
    check("rst_arready", m_ARREADY_o, 0);
    check("rst_s_arvalid", s_ARVALID_o, 0);
    check("rst_s_araddr", s_ARADDR_o, 0);
    check("rst_m_rvalid", m_RVALID_o, 0);
    check("rst_s_rready", s_RREADY_o, 0);
    check("rst_m_rlast", m_RLAST_o, 0);
    @(negedge ACLK_i);

    // Single request from master 1.
    set_ar(1, 32'h4000_0010, 5'h11, 3'd2);
    m_ARVALID_i = 2'b10;
    s_ARREADY_i = 1'b1;
    #1 check("m1_arready", m_ARREADY_o, 2'b10);
    @(negedge ACLK_i);
    m_ARVALID_i = 2'b00;
    #1;
    check("m1_s_arvalid", s_ARVALID_o, 1);
    check("m1_s_araddr", s_ARADDR_o, 32'h4000_0010);
    check("m1_s_arid", s_ARID_o, 5'h11);
    check("m1_s_arlen", s_ARLEN_o, 3'd2);
    @(negedge ACLK_i);
    check("m1_s_arvalid_drop", s_ARVALID_o, 0);
    s_RVALID_i = 1'b1;
    s_RLAST_i  = 1'b1;
    s_RDATA_i  = 32'hCAFE_0001;
    s_RID_i    = 5'h11;
    m_RREADY_i = 2'b10;
    #1;
    check("m1_m_rvalid", m_RVALID_o, 2'b10);
    check("m1_s_rready", s_RREADY_o, 1);
    check("m1_m_rdata", m_RDATA_o, 32'hCAFE_0001);
    check("m1_m_rid", m_RID_o, 5'h11);
    @(negedge ACLK_i);
    s_RVALID_i = 1'b0;
    s_RLAST_i  = 1'b0;

    // Both masters requesting: alternate 0,1,0,1 with no bubble on the slave side.
    set_ar(0, 32'h0000_1000, 5'h01, 3'd3);
    set_ar(1, 32'h0000_2000, 5'h02, 3'd3);
    m_ARVALID_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_grant%0d", i), m_ARREADY_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        check($sformatf("rr_s_arvalid%0d", i), s_ARVALID_o, 1);
        check($sformatf("rr_s_araddr%0d", i), s_ARADDR_o,
              ((i - 1) % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
      end
      @(negedge ACLK_i);
    end
    m_ARVALID_i = 2'b00;
    #1;
    check("rr_s_arvalid_last", s_ARVALID_o, 1);
    check("rr_s_araddr_last", s_ARADDR_o, 32'h0000_2000);
    @(negedge ACLK_i);
    check("rr_s_arvalid_idle", s_ARVALID_o, 0);

    // R bursts of four beats for owners 0,1,0,1; one stall from master 0 in the first burst.
    for (int b = 0; b < 4; b++) begin
      for (int beat = 0; beat < 4; beat++) begin
        s_RVALID_i = 1'b1;
        s_RLAST_i  = (beat == 3);
        s_RDATA_i  = 32'hD000_0000 | (b << 4) | beat;
        m_RREADY_i = 2'b11;
        if (b == 0 && beat == 1) begin
          m_RREADY_i = 2'b10;
          #1;
          check("r_stall_s_rready", s_RREADY_o, 0);
          check("r_stall_m_rvalid", m_RVALID_o, 2'b01);
          @(negedge ACLK_i);
          m_RREADY_i = 2'b11;
        end
        #1;
        check($sformatf("r_b%0d_m_rvalid%0d", b, beat), m_RVALID_o, owner[b]);
        check($sformatf("r_b%0d_s_rready%0d", b, beat), s_RREADY_o, 1);
        check($sformatf("r_b%0d_rlast%0d", b, beat), m_RLAST_o, (beat == 3));
        @(negedge ACLK_i);
      end
    end
    // No outstanding reads: a stray beat is held off.
    s_RVALID_i = 1'b1;
    s_RLAST_i  = 1'b1;
    #1;
    check("empty_s_rready", s_RREADY_o, 0);
    check("empty_m_rvalid", m_RVALID_o, 0);
    @(negedge ACLK_i);
    s_RVALID_i = 1'b0;
    s_RLAST_i  = 1'b0;

    // Fill the eight outstanding slots from master 0.
    set_ar(0, 32'h0000_3000, 5'h03, 3'd0);
    m_ARVALID_i = 2'b01;
    s_ARREADY_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 check($sformatf("fill_grant%0d", i), m_ARREADY_o, 2'b01);
      @(negedge ACLK_i);
    end
    #1 check("full_blocked", m_ARREADY_o, 2'b00);
    @(negedge ACLK_i);
    #1 check("full_blocked2", m_ARREADY_o, 2'b00);
    s_RVALID_i = 1'b1;
    s_RLAST_i  = 1'b1;
    m_RREADY_i = 2'b01;
    #1;
    check("full_pop_same_cycle", m_ARREADY_o, 2'b00);
    check("full_pop_s_rready", s_RREADY_o, 1);
    @(negedge ACLK_i);
    s_RVALID_i = 1'b0;
    #1 check("full_regrant", m_ARREADY_o, 2'b01);
    @(negedge ACLK_i);
    m_ARVALID_i = 2'b00;

    // Retire two entries to leave room for the stall test.
    s_RVALID_i = 1'b1;
    @(negedge ACLK_i);
    @(negedge ACLK_i);
    s_RVALID_i = 1'b0;
    s_RLAST_i  = 1'b0;

    // Slave stalls AR for five cycles: fields stable, no grants, pointer held.
    set_ar(0, 32'h5000_0000, 5'h05, 3'd1);
    m_ARVALID_i = 2'b01;
    s_ARREADY_i = 1'b0;
    #1 check("stall_first_grant", m_ARREADY_o, 2'b01);
    @(negedge ACLK_i);
    set_ar(0, 32'h6000_0000, 5'h06, 3'd1);
    set_ar(1, 32'h7000_0000, 5'h07, 3'd1);
    m_ARVALID_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall_arready%0d", i), m_ARREADY_o, 2'b00);
      check($sformatf("stall_s_arvalid%0d", i), s_ARVALID_o, 1);
      check($sformatf("stall_s_araddr%0d", i), s_ARADDR_o, 32'h5000_0000);
      check($sformatf("stall_s_arid%0d", i), s_ARID_o, 5'h05);
      @(negedge ACLK_i);
    end
    s_ARREADY_i = 1'b1;
    #1 check("stall_release_grant", m_ARREADY_o, 2'b10);
    @(negedge ACLK_i);
    m_ARVALID_i = 2'b00;
    s_ARREADY_i = 1'b0;
    #1;
    check("stall_next_s_araddr", s_ARADDR_o, 32'h7000_0000);
    check("stall_next_s_arvalid", s_ARVALID_o, 1);

    // Reset in the middle of traffic discards AR and R state.
    s_RVALID_i = 1'b1;
    m_RREADY_i = 2'b11;
    #1 check("midrst_pre_s_rready", s_RREADY_o, 1);
    ARESET_i = 1'b1;
    @(negedge ACLK_i);
    ARESET_i = 1'b0;
    #1;
    check("midrst_s_arvalid", s_ARVALID_o, 0);
    check("midrst_s_araddr", s_ARADDR_o, 0);
    check("midrst_s_rready", s_RREADY_o, 0);
    check("midrst_m_rvalid", m_RVALID_o, 0);
    @(negedge ACLK_i);
    s_RVALID_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
